// File: rtl/pulse_length_monitor_mc.sv
// Multi-channel pulse length monitor: per-channel synchronise/debounce, interval
// counting, exponential averaging, and a round-robin event stream of captured lengths.
module pulse_length_monitor_mc #(
    parameter int  CHANNELS    = 4,
    parameter int  COUNT_WIDTH = 16,
    parameter int  FILTER_BITS = 4,
    parameter int  DEBOUNCE_N  = 2,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [CHANNELS-1:0]             signal_i,
    output logic [CHANNELS*COUNT_WIDTH-1:0] length_pos_o,
    output logic [CHANNELS*COUNT_WIDTH-1:0] length_neg_o,
    output logic [CHANNELS-1:0]             stuck_o,
    output logic [CHANNELS-1:0]             overrun_o,
    input  logic [CHANNELS-1:0]             ovr_clr_i,
    output logic                            rd_valid_o,
    input  logic                            rd_ready_i,
    output logic [CH_W-1:0]                 rd_channel_o,
    output logic                            rd_level_o,
    output logic [COUNT_WIDTH-1:0]          rd_length_o
);
    localparam int DB_W = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
    localparam int FW   = COUNT_WIDTH + FILTER_BITS;

    // Handshake: an event transfers on a rising edge where rd_valid_o && rd_ready_i;
    // while rd_valid_o=1 and rd_ready_i=0 the payload is held unchanged.

    logic [CHANNELS-1:0]    lvl_w;
    logic [CHANNELS-1:0]    cap_w;
    logic [COUNT_WIDTH-1:0] cnt_w [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic                   sync1_q, sync2_q, lvl_q, armed_q, stuck_q, edge_c;
        logic [DB_W-1:0]        db_q;
        logic [COUNT_WIDTH-1:0] cnt_q;
        logic [FW-1:0]          fpos_q, fneg_q;

        // The filtered level flips on the DEBOUNCE_N-th consecutive differing sample.
        assign edge_c   = (sync2_q != lvl_q) && (db_q == DB_W'(DEBOUNCE_N - 1));
        assign lvl_w[k] = lvl_q;
        assign cap_w[k] = edge_c && armed_q;
        assign cnt_w[k] = cnt_q;
        assign stuck_o[k] = stuck_q;
        assign length_pos_o[k*COUNT_WIDTH +: COUNT_WIDTH] = fpos_q[FILTER_BITS +: COUNT_WIDTH];
        assign length_neg_o[k*COUNT_WIDTH +: COUNT_WIDTH] = fneg_q[FILTER_BITS +: COUNT_WIDTH];

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                lvl_q   <= 1'b0;
                db_q    <= '0;
                armed_q <= 1'b0;
                cnt_q   <= '0;
                stuck_q <= 1'b0;
                fpos_q  <= '0;
                fneg_q  <= '0;
            end else begin
                sync1_q <= signal_i[k];
                sync2_q <= sync1_q;
                if (edge_c) begin
                    lvl_q <= sync2_q;
                    db_q  <= '0;
                end else if (sync2_q != lvl_q) begin
                    db_q <= db_q + DB_W'(1);
                end else begin
                    db_q <= '0;
                end
                armed_q <= armed_q || edge_c;
                if (edge_c)
                    cnt_q <= COUNT_WIDTH'(1);
                else if (cnt_q != '1)
                    cnt_q <= cnt_q + COUNT_WIDTH'(1);
                stuck_q <= !edge_c && (stuck_q || (cnt_q == '1));
                // The capture belongs to the level that is ending (lvl_q before the flip).
                if (cap_w[k] && lvl_q)
                    fpos_q <= fpos_q + FW'(cnt_q) - FW'(fpos_q[FILTER_BITS +: COUNT_WIDTH]);
                if (cap_w[k] && !lvl_q)
                    fneg_q <= fneg_q + FW'(cnt_q) - FW'(fneg_q[FILTER_BITS +: COUNT_WIDTH]);
            end
        end
    end

    logic [CHANNELS-1:0]    pend_v_q, pend_lvl_q, gnt_c;
    logic [COUNT_WIDTH-1:0] pend_len_q [CHANNELS];
    logic [CH_W-1:0]        last_q, gnt_idx;
    logic                   gnt_found, load_c, grant_c;
    int                     j;

    assign load_c  = !rd_valid_o || rd_ready_i;
    assign grant_c = load_c && gnt_found;

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            j = (int'(last_q) + i) % CHANNELS;
            if (!gnt_found && pend_v_q[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(j);
            end
        end
    end

    always_comb begin
        gnt_c = '0;
        if (grant_c)
            gnt_c[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_v_q     <= '0;
            pend_lvl_q   <= '0;
            overrun_o    <= '0;
            rd_valid_o   <= 1'b0;
            rd_channel_o <= '0;
            rd_level_o   <= 1'b0;
            rd_length_o  <= '0;
            last_q       <= CH_W'(CHANNELS - 1);
            for (int k = 0; k < CHANNELS; k++)
                pend_len_q[k] <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                // A capture in the grant cycle refills the slot after the old event leaves.
                if (cap_w[k]) begin
                    pend_v_q[k]   <= 1'b1;
                    pend_lvl_q[k] <= lvl_w[k];
                    pend_len_q[k] <= cnt_w[k];
                end else if (gnt_c[k]) begin
                    pend_v_q[k] <= 1'b0;
                end
                overrun_o[k] <= (cap_w[k] && pend_v_q[k] && !gnt_c[k]) ||
                                (overrun_o[k] && !ovr_clr_i[k]);
            end
            if (load_c) begin
                rd_valid_o <= gnt_found;
                if (gnt_found) begin
                    rd_channel_o <= gnt_idx;
                    rd_level_o   <= pend_lvl_q[gnt_idx];
                    rd_length_o  <= pend_len_q[gnt_idx];
                    last_q       <= gnt_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_pulse_length_monitor_mc.sv
// Bench for pulse_length_monitor_mc: directed waveforms, per-channel event
// scoreboard driven from the waveform durations, and an averaging model.
module tb_pulse_length_monitor_mc;
    localparam int CH = 4;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   sig = '0;
    logic [CH-1:0]   ovr_clr = '0;
    logic            rd_ready = 1'b1;
    logic [CH*CW-1:0] length_pos, length_neg;
    logic [CH-1:0]   stuck, overrun;
    logic            rd_valid, rd_level;
    logic [1:0]      rd_channel;
    logic [CW-1:0]   rd_length;

    pulse_length_monitor_mc dut (
        .clk_i(clk), .rst_n_i(rst_n), .signal_i(sig),
        .length_pos_o(length_pos), .length_neg_o(length_neg),
        .stuck_o(stuck), .overrun_o(overrun), .ovr_clr_i(ovr_clr),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
        .rd_channel_o(rd_channel), .rd_level_o(rd_level), .rd_length_o(rd_length)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int t = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: expected events per channel as {level, length}, plus averages.
    logic [CW:0] exp_q [CH][$];
    bit          armed_m [CH];
    int          last_t [CH];
    int          fpos_m [CH];
    int          fneg_m [CH];

    int  hs_count = 0;
    bit  log_en = 0;
    int  log_n = 0;
    int  log_ch [8];
    int  log_cyc [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    // Changes channel ch to val; the level that ends lasted (t - last_t) cycles.
    task automatic drive(input int ch, input logic val, input bit record);
        int len;
        len = t - last_t[ch];
        if (len > 65535) len = 65535;
        if (armed_m[ch]) begin
            if (val == 1'b0) fpos_m[ch] = fpos_m[ch] + len - (fpos_m[ch] >> 4);
            else             fneg_m[ch] = fneg_m[ch] + len - (fneg_m[ch] >> 4);
            if (record) exp_q[ch].push_back({~val, 16'(len)});
        end
        armed_m[ch] = 1'b1;
        last_t[ch]  = t;
        sig[ch]     = val;
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            armed_m[k] = 0;
            fpos_m[k]  = 0;
            fneg_m[k]  = 0;
            exp_q[k].delete();
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"},   rd_valid, 0);
        check({name, "_channel"}, rd_channel, 0);
        check({name, "_level"},   rd_level, 0);
        check({name, "_length"},  rd_length, 0);
        check({name, "_stuck"},   stuck, 0);
        check({name, "_overrun"}, overrun, 0);
        check({name, "_lpos"},    length_pos, 0);
        check({name, "_lneg"},    length_neg, 0);
    endtask

    task automatic check_queues_empty(input string name);
        for (int k = 0; k < CH; k++)
            check($sformatf("%s_q%0d_empty", name, k), exp_q[k].size(), 0);
    endtask

    // Compare process: every accepted event against the scoreboard, and payload
    // stability across stalled cycles.
    logic        hold_prev = 0;
    logic [18:0] prev_pl;
    logic [CW:0] e;
    int          ch_s;
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (hold_prev) begin
                check("hold_valid", rd_valid, 1);
                check("hold_payload", {rd_channel, rd_level, rd_length}, prev_pl);
            end
            if (rd_valid && rd_ready) begin
                ch_s = int'(rd_channel);
                if (exp_q[ch_s].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: got ch%0d level %0d length %0d expected none",
                             ch_s, rd_level, rd_length);
                end else begin
                    e = exp_q[ch_s].pop_front();
                    check($sformatf("event_ch%0d", ch_s), {rd_level, rd_length}, e);
                end
                hs_count++;
                if (log_en && log_n < 8) begin
                    log_ch[log_n]  = ch_s;
                    log_cyc[log_n] = cyc;
                    log_n++;
                end
            end
            hold_prev = rd_valid && !rd_ready;
            prev_pl   = {rd_channel, rd_level, rd_length};
        end else begin
            hold_prev = 0;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    logic v0, v1;
    int   n, hs_before;

    initial begin
        model_reset();
        for (int k = 0; k < CH; k++) last_t[k] = 0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        t = 0;

        // ch0 30/70 square wave, ch1 long high, ch2 single-cycle glitches.
        for (int i = 0; i < 70200; i++) begin
            v0 = (t >= 200) && (t < 20200) && (((t - 200) % 100) < 30);
            if (v0 != sig[0]) drive(0, v0, 1);
            v1 = (t >= 100) && (t < 70100);
            if (v1 != sig[1]) drive(1, v1, 1);
            sig[2] = (t % 50 == 10) && (t < 70100);
            if (t == 60000) check("stuck2_early", stuck[2], 0);
            if (t == 67000) check("stuck2_sat", stuck[2], 1);
            if (t == 65000) check("stuck1_early", stuck[1], 0);
            if (t == 66500) check("stuck1_sat", stuck[1], 1);
            if (t == 70099) check("stuck1_before_fall", stuck[1], 1);
            tick(1);
        end
        check("stuck1_cleared", stuck[1], 0);
        check("lpos0_model", length_pos[0 +: CW], fpos_m[0] >> 4);
        check("lneg0_model", length_neg[0 +: CW], fneg_m[0] >> 4);
        check("lpos0_lit", length_pos[0 +: CW], 30);
        check("lneg0_lit", length_neg[0 +: CW], 70);
        check("lpos1_lit", length_pos[CW +: CW], 4095);
        check("lpos2_zero", length_pos[2*CW +: CW], 0);
        check("lneg2_zero", length_neg[2*CW +: CW], 0);
        check("p1_overrun", overrun, 0);
        check("p1_idle", rd_valid, 0);
        check_queues_empty("p1");

        // ch3 overrun with the output register stalled.
        rd_ready = 1'b0;
        check("stuck3_sat", stuck[3], 1);
        drive(3, 1'b1, 0);
        tick(30);
        check("stuck3_cleared", stuck[3], 0);
        drive(3, 1'b0, 1);
        tick(40);
        drive(3, 1'b1, 0);
        tick(50);
        drive(3, 1'b0, 0);
        exp_q[3].push_back({1'b1, 16'd50});
        tick(10);
        check("p2_valid", rd_valid, 1);
        check("p2_channel", rd_channel, 3);
        check("p2_level", rd_level, 1);
        check("p2_length", rd_length, 30);
        check("p2_overrun_set", overrun, 4'b1000);
        ovr_clr = 4'b1000;
        tick(1);
        ovr_clr = '0;
        check("p2_overrun_clr", overrun, 0);
        rd_ready = 1'b1;
        tick(6);
        check("p2_drained", rd_valid, 0);
        check_queues_empty("p2");

        // Reset asserted while an event is being offered.
        rd_ready = 1'b0;
        drive(3, 1'b1, 0);
        n = 0;
        while (!rd_valid && n < 20) begin
            tick(1);
            n++;
        end
        check("p3_valid_before_reset", rd_valid, 1);
        #2;
        rst_n = 1'b0;
        sig = '0;
        #1;
        check_idle("async_reset");
        model_reset();
        tick(3);
        rst_n = 1'b1;

        // First edges after reset are discarded, then four simultaneous captures.
        rd_ready = 1'b1;
        tick(5);
        hs_before = hs_count;
        for (int k = 0; k < CH; k++) drive(k, 1'b1, 1);
        tick(25);
        check("p4_discard", hs_count, hs_before);
        log_n = 0;
        log_en = 1;
        for (int k = 0; k < CH; k++) drive(k, 1'b0, 1);
        tick(12);
        log_en = 0;
        check("p4_count", log_n, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("p4_order%0d", i), log_ch[i], i);
        for (int i = 1; i < 4; i++)
            check($sformatf("p4_gap%0d", i), log_cyc[i] - log_cyc[i-1], 1);
        check("p4_overrun", overrun, 0);
        check("p4_lpos0_lit", length_pos[0 +: CW], 1);
        for (int k = 0; k < CH; k++) begin
            check($sformatf("p4_lpos%0d", k), length_pos[k*CW +: CW], fpos_m[k] >> 4);
            check($sformatf("p4_lneg%0d", k), length_neg[k*CW +: CW], 0);
        end
        check_queues_empty("p4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
